trap_controller: RTL

//  Trap source side of the machine-mode trap path. Collects exceptions and interrupts,

---
 rtl/trap_if.sv | 21 ++
 rtl/trap_controller.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/trap_if.sv
// Trap redirect handshake between the trap controller and fetch.
// The controller holds redirect/trapPC until fetch answers with trapAck.
interface trap_if #(
  parameter int N = 64
);
  logic [N-1:0] trapPC;
  logic         redirect;
  logic         trapAck;

  modport master (
    output trapPC,
    output redirect,
    input  trapAck
  );

  modport slave (
    input  trapPC,
    input  redirect,
    output trapAck
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap source: cause select, trap/return FSM, PC redirect.
// Optional VECTORED_TRAP_EN: vectored interrupt handler addresses.
module trap_controller #(
  parameter int N      = 64,
  parameter int NCAUSE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCAUSE-1:0] excPending,
  input  logic [NCAUSE-1:0] irqPending,
  input  logic [N-1:0]      mie,
  input  logic [N-1:0]      mstatus,
  input  logic [N-1:0]      mtvec,
  input  logic [N-1:0]      pcCurrent,
  input  logic              mretExec,
  output logic [NCAUSE-1:0] trapTrigger,
  output logic              trapReturn,
  output logic [N-1:0]      mcause,
  output logic [N-1:0]      mepc,
  trap_if.master            fe
);

  localparam int CW = $clog2(NCAUSE);
  localparam int W  = (NCAUSE < 12) ? 12 : NCAUSE;

  typedef enum logic [1:0] {
    IDLE,
    TRAP,
    HANDLER,
    RETURN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_code;
  logic            r_isIrq;
  logic [N-1:0]    r_mcause;
  logic [N-1:0]    r_mepc;

  logic [NCAUSE-1:0] w_irq;
  logic [W-1:0]      w_irqW;
  logic              w_excAny;
  logic              w_irqAny;
  logic [CW-1:0]     w_excCode;
  logic [CW-1:0]     w_irqCode;
  logic [CW-1:0]     w_code;
  logic              w_isIrq;
  logic              w_take;
  logic [N-1:0]      w_cause;
  logic [N-1:0]      w_base;
  logic [N-1:0]      w_hand;
  logic              w_unused;

  assign w_irq    = irqPending & mie[NCAUSE-1:0]
                  & {NCAUSE{mstatus[3]}};
  assign w_irqW   = W'(w_irq);
  assign w_excAny = |excPending;
  assign w_irqAny = |w_irq;
  assign w_unused = ^{mie, mstatus, mtvec[1:0]};

  always_comb begin
    w_excCode = '0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (excPending[i]) w_excCode = CW'(i);
    end
    w_irqCode = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (w_irqW[i]) w_irqCode = CW'(i);
    end
    // Later assignments win: 11 over 3 over 7 over lowest index.
    if (w_irqW[7])  w_irqCode = CW'(7);
    if (w_irqW[3])  w_irqCode = CW'(3);
    if (w_irqW[11]) w_irqCode = CW'(11);
  end

  assign w_isIrq = !w_excAny;
  assign w_code  = w_excAny ? w_excCode : w_irqCode;

  always_comb begin
    w_cause           = '0;
    w_cause[CW-1:0]   = w_code;
    w_cause[N-1]      = w_isIrq;
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_excAny || w_irqAny) begin
          w_next = TRAP;
          w_take = 1'b1;
        end
      end
      TRAP: begin
        if (fe.trapAck) w_next = HANDLER;
      end
      HANDLER: begin
        // A nested exception drops a coincident mret.
        if (w_excAny) begin
          w_next = TRAP;
          w_take = 1'b1;
        end else if (mretExec) begin
          w_next = RETURN;
        end
      end
      RETURN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_code   <= '0;
      r_isIrq  <= 1'b0;
      r_mcause <= '0;
      r_mepc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_code   <= w_code;
        r_isIrq  <= w_isIrq;
        r_mcause <= w_cause;
        r_mepc   <= {pcCurrent[N-1:2], 2'b00};
      end
    end
  end

  assign w_base = {mtvec[N-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
  assign w_hand = (mtvec[1:0] == 2'b01 && r_isIrq)
                ? w_base + (N'(r_code) << 2)
                : w_base;
`else
  assign w_hand = w_base;
`endif

  always_comb begin
    trapTrigger = '0;
    trapReturn  = 1'b0;
    fe.redirect = 1'b0;
    fe.trapPC   = '0;
    unique case (r_state)
      TRAP: begin
        trapTrigger = NCAUSE'(1) << r_code;
        fe.redirect = 1'b1;
        fe.trapPC   = w_hand;
      end
      RETURN: begin
        trapReturn  = 1'b1;
        fe.redirect = 1'b1;
        fe.trapPC   = r_mepc;
      end
      default: ;
    endcase
  end

  assign mcause = r_mcause;
  assign mepc   = r_mepc;

endmodule
